neuron_param_loader: RTL and testbench

NEURON_PARAM_LOADER -- requirements
Module: neuron_param_loader

---
 rtl/neuron_param_loader_pkg.sv | 19 +
 rtl/neuron_param_loader.sv | 135 +++++++++++++
 tb/tb_neuron_param_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_param_loader_pkg.sv
// Shared widths and FSM encoding for the neuron parameter loader.
package neuron_param_loader_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CFG_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WEIGHTS = 2'd1,
    ST_BIAS    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // States in which the loader accepts host words.
  function automatic logic is_load_state(input state_t st);
    return (st == ST_WEIGHTS) || (st == ST_BIAS);
  endfunction

endpackage

// File: rtl/neuron_param_loader.sv
// Streams per-neuron weights then bias from a valid/ready host port to the
// neuron array, tagging each word with the target layer and neuron numbers.
module neuron_param_loader
  import neuron_param_loader_pkg::*;
#(
  parameter int unsigned layerNo    = 1,
  parameter int unsigned numNeurons = 32,
  parameter int unsigned numWeight  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] weightValue,
  output logic              weightValid,
  output logic [DATA_W-1:0] biasValue,
  output logic              biasValid,
  output logic [CFG_W-1:0]  config_layer_num,
  output logic [CFG_W-1:0]  config_neuron_num,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W_W = $clog2(numWeight) + 1;
  localparam int unsigned N_W = $clog2(numNeurons) + 1;
  localparam logic [CFG_W-1:0] CFG_NONE = '1;

  state_t            state, state_nxt;
  logic [W_W-1:0]    w, w_nxt;
  logic [N_W-1:0]    n, n_nxt;
  logic              accept;
  logic              s_ready_nxt, busy_nxt, done_nxt;
  logic              weight_valid_nxt, bias_valid_nxt;
  logic [DATA_W-1:0] weight_value_nxt, bias_value_nxt;
  logic [CFG_W-1:0]  layer_nxt, neuron_nxt;

  assign accept = s_valid & s_ready;

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      w                 <= '0;
      n                 <= '0;
      s_ready           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      weightValue       <= '0;
      biasValue         <= '0;
      config_layer_num  <= CFG_NONE;
      config_neuron_num <= CFG_NONE;
    end else begin
      state             <= state_nxt;
      w                 <= w_nxt;
      n                 <= n_nxt;
      s_ready           <= s_ready_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      weightValid       <= weight_valid_nxt;
      biasValid         <= bias_valid_nxt;
      weightValue       <= weight_value_nxt;
      biasValue         <= bias_value_nxt;
      config_layer_num  <= layer_nxt;
      config_neuron_num <= neuron_nxt;
    end
  end

  // Next state and next output values; config numbers are presented with
  // each valid and parked at all-ones once the load completes.
  always_comb begin
    state_nxt        = state;
    w_nxt            = w;
    n_nxt            = n;
    done_nxt         = 1'b0;
    weight_valid_nxt = 1'b0;
    bias_valid_nxt   = 1'b0;
    weight_value_nxt = weightValue;
    bias_value_nxt   = biasValue;
    layer_nxt        = config_layer_num;
    neuron_nxt       = config_neuron_num;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WEIGHTS;
          w_nxt     = '0;
          n_nxt     = '0;
        end
      end
      ST_WEIGHTS: begin
        if (accept) begin
          weight_valid_nxt = 1'b1;
          weight_value_nxt = s_data;
          layer_nxt        = CFG_W'(layerNo);
          neuron_nxt       = CFG_W'(n);
          if (w == W_W'(numWeight - 1)) begin
            w_nxt     = '0;
            state_nxt = ST_BIAS;
          end else begin
            w_nxt = w + W_W'(1);
          end
        end
      end
      ST_BIAS: begin
        if (accept) begin
          bias_valid_nxt = 1'b1;
          bias_value_nxt = s_data;
          layer_nxt      = CFG_W'(layerNo);
          neuron_nxt     = CFG_W'(n);
          if (n == N_W'(numNeurons - 1)) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            n_nxt     = n + N_W'(1);
            state_nxt = ST_WEIGHTS;
          end
        end
      end
      ST_DONE: begin
        state_nxt  = ST_IDLE;
        layer_nxt  = CFG_NONE;
        neuron_nxt = CFG_NONE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    s_ready_nxt = is_load_state(state_nxt);
    busy_nxt    = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed self-checking bench for neuron_param_loader (4 weights, 2 neurons).
module tb_neuron_param_loader;
  import neuron_param_loader_pkg::*;

  localparam int unsigned NW = 4;
  localparam int unsigned NN = 2;
  localparam int unsigned LAYER = 1;
  localparam int unsigned NWORDS = (NW + 1) * NN;
  localparam logic [CFG_W-1:0] ALL1 = '1;

  typedef struct packed {
    logic [1:0]        kind;   // 1 = weight, 2 = bias
    logic              done;
    logic [DATA_W-1:0] value;
    logic [CFG_W-1:0]  neuron;
    logic [CFG_W-1:0]  layer;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst, start, s_valid, s_ready;
  logic [DATA_W-1:0] s_data, weightValue, biasValue;
  logic              weightValid, biasValid, busy, done;
  logic [CFG_W-1:0]  config_layer_num, config_neuron_num;

  int checks = 0;
  int failures = 0;
  ev_t evq[$];
  int  done_cnt = 0;

  neuron_param_loader #(.layerNo(LAYER), .numNeurons(NN), .numWeight(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .weightValue(weightValue), .weightValid(weightValid),
    .biasValue(biasValue), .biasValid(biasValid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (weightValid || biasValid)
      check("wv_bv_excl", 64'(weightValid & biasValid), 64'd0);
    if (weightValid)
      evq.push_back('{kind: 2'd1, done: done, value: weightValue,
                      neuron: config_neuron_num, layer: config_layer_num});
    if (biasValid)
      evq.push_back('{kind: 2'd2, done: done, value: biasValue,
                      neuron: config_neuron_num, layer: config_layer_num});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_s_ready"}, 64'(s_ready), 64'd0);
    check({pfx, "_wvalid"},  64'(weightValid), 64'd0);
    check({pfx, "_bvalid"},  64'(biasValid), 64'd0);
    check({pfx, "_done"},    64'(done), 64'd0);
    check({pfx, "_busy"},    64'(busy), 64'd0);
    check({pfx, "_wvalue"},  64'(weightValue), 64'd0);
    check({pfx, "_bvalue"},  64'(biasValue), 64'd0);
    check({pfx, "_cfg_n"},   64'(config_neuron_num), 64'(ALL1));
    check({pfx, "_cfg_l"},   64'(config_layer_num), 64'(ALL1));
  endtask

  // Feeds words 1..stop_at with optional gaps and a stray start mid-load.
  task automatic feed(input bit gaps, input bit mid_start, input int stop_at);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit mid_done = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = DATA_W'(1);
    while (idx < stop_at && cyc < 200) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
      cyc++;
      start = 1'b0;
      if (mid_start && idx == 2 && !mid_done) begin
        start    = 1'b1;
        mid_done = 1'b1;
      end
      s_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      s_data  = DATA_W'(idx + 1);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("feed_accepts", 64'(idx), 64'(stop_at));
  endtask

  task automatic run_load(input string pfx, input bit gaps, input bit mid_start);
    int q0 = evq.size();
    int d0 = done_cnt;
    int nw = 0;
    int k;
    ev_t e;
    feed(gaps, mid_start, NWORDS);
    repeat (3) tick();
    check({pfx, "_ev_count"}, 64'(evq.size() - q0), 64'(NWORDS));
    check({pfx, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    if (evq.size() - q0 == NWORDS) begin
      for (int i = 0; i < int'(NN); i++) begin
        for (int j = 0; j <= int'(NW); j++) begin
          k = q0 + i * int'(NW + 1) + j;
          e = evq[k];
          if (e.kind == 2'd1) nw++;
          check($sformatf("%s_kind%0d", pfx, k - q0), 64'(e.kind),
                (j == int'(NW)) ? 64'd2 : 64'd1);
          check($sformatf("%s_val%0d", pfx, k - q0), 64'(e.value),
                64'(1 + i * int'(NW + 1) + j));
          check($sformatf("%s_nrn%0d", pfx, k - q0), 64'(e.neuron), 64'(i));
          check($sformatf("%s_lyr%0d", pfx, k - q0), 64'(e.layer), 64'(LAYER));
          check($sformatf("%s_done%0d", pfx, k - q0), 64'(e.done),
                64'((i == int'(NN) - 1) && (j == int'(NW))));
        end
      end
      check({pfx, "_weight_pulses"}, 64'(nw), 64'(NW * NN));
    end
    check({pfx, "_busy_after"}, 64'(busy), 64'd0);
    check({pfx, "_cfg_n_after"}, 64'(config_neuron_num), 64'(ALL1));
    check({pfx, "_bvalue_hold"}, 64'(biasValue), 64'(NWORDS));
    check({pfx, "_wvalue_hold"}, 64'(weightValue), 64'(NWORDS - 1));
  endtask

  initial begin
    int d0;
    int q0;
    rst = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (2) tick();
    rst = 1'b0; start = 1'b0;
    check_reset_values("rst");
    tick();
    check("start_in_rst_busy", 64'(busy), 64'd0);

    // s_valid in IDLE must be refused.
    q0 = evq.size();
    s_valid = 1'b1; s_data = DATA_W'(16'h55);
    repeat (3) begin
      tick();
      check("idle_s_ready", 64'(s_ready), 64'd0);
      check("idle_cfg_n", 64'(config_neuron_num), 64'(ALL1));
    end
    s_valid = 1'b0;
    tick();
    check("idle_no_events", 64'(evq.size() - q0), 64'd0);

    run_load("cont", 1'b0, 1'b0);
    run_load("gap", 1'b1, 1'b0);
    run_load("midstart", 1'b0, 1'b1);

    // Abort after three weights of neuron 0.
    d0 = done_cnt;
    q0 = evq.size();
    feed(1'b0, 1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("abort");
    check("abort_events", 64'(evq.size() - q0), 64'd3);
    repeat (2) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_load("reload", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
